im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//  Write side of the instruction memory: receives a program as a byte stream
//  (valid/ready), packs bytes big-endian into 32-bit MIPS words, and issues
//  write strobes into the IM that PC/IM fetch from. Holds the core (cpu_hold)
//  from reset until a load completes.
// PARAMETERS
//  ADDR_W  8    word-index width; IM depth = 2**ADDR_W words
// PORTS
//  clk         in   1         system clock, rising edge
//  rst_n       in   1         asynchronous reset, active low
//  start       in   1         1-cycle pulse: begin load (accepted in IDLE/DONE/ERR)
//  len         in   ADDR_W+1  program length in words, sampled on accepted start
//  byte_valid  in   1         byte_data valid
//  byte_data   in   8         program byte, MSB-first per word
//  byte_ready  out  1         loader can accept a byte this cycle
//  im_we       out  1         IM write strobe, 1 cycle per word
//  im_waddr    out  32        IM byte address = word_index<<2 (bits [1:0]=0)
//  im_wdata    out  32        assembled instruction word
//  cpu_hold    out  1         1 = core stalled (PC must not advance)
//  done        out  1         load finished OK (level)
//  err         out  1         load rejected (level)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; byte_ready=0, im_we=0, im_waddr=0,
//    im_wdata=0, cpu_hold=1, done=0, err=0; byte counter/word index = 0.
//    Reset mid-load aborts; IM keeps partially written words.
//  - Transfer: byte accepted iff byte_valid && byte_ready on a clk edge.
//    1st byte of word -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
//  - FSM:
//    IDLE : cpu_hold=1. start -> latch len; len==0 -> DONE; len>2**ADDR_W
//           -> ERR; else LOAD, word index=0.
//    LOAD : byte_ready=1. 4th accepted byte -> WRITE.
//    WRITE: 1 cycle; byte_ready=0, im_we=1, im_waddr=idx<<2, im_wdata=word.
//           idx+1==len -> DONE (or CSUM, see CONFIGURATION), else idx+1, LOAD.
//    DONE : done=1, cpu_hold=0. start -> re-latch len, cpu_hold=1, done=0,
//           proceeds as from IDLE.
//    ERR  : err=1, cpu_hold=1. start -> as from IDLE, err cleared.
//  - Latency: last byte accepted at edge N -> im_we high cycle N+1 ->
//    done/cpu_hold=0 from cycle N+2. Throughput max 1 word per 5 cycles.
//  - start while LOAD/WRITE/CSUM: ignored. byte_valid in IDLE/DONE/ERR:
//    ignored (ready=0, bytes not consumed).
//  - im_waddr/im_wdata hold last value when im_we=0; im_we never asserted
//    outside WRITE. Word index wraps never (bounded by len check).
// CONFIGURATION
//  CHECKSUM_EN defined: after final WRITE enter CSUM (byte_ready=1); next
//    accepted byte compared to XOR of all program bytes of this load
//    (accumulator cleared on accepted start): equal -> DONE, else ERR.
//    len==0 -> CSUM expects byte 0x00.
//  CHECKSUM_EN undefined: no CSUM state, no trailing byte; last WRITE -> DONE.
// TESTING
//  1 reset: after rst_n low, cpu_hold=1, done=0, err=0, byte_ready=0, im_we=0.
//  2 start,len=2; bytes 20 08 00 05 3C 01 12 34 back-to-back -> im_we pulses:
//    addr 0x0 data 0x20080005, addr 0x4 data 0x3C011234; then done=1,
//    cpu_hold=0 two cycles after last byte.
//  3 byte_valid toggled 1/0 every cycle during len=1 load of 8C 22 00 04 ->
//    single write 0x8C220004 at addr 0; no byte lost or duplicated.
//  4 len=0 -> DONE next cycle, no im_we; len=2**ADDR_W+1 -> err=1,
//    cpu_hold=1, no im_we; start with len=1 from ERR recovers.
//  5 rst_n low after 2 bytes of a word -> IDLE, no im_we; fresh load from
//    addr 0 works; start pulsed mid-LOAD -> ignored, address sequence intact.
//  6 CHECKSUM_EN: len=1, bytes 01 02 03 04 + 04 -> done=1; trailer 05 ->
//    err=1, cpu_hold=1 (word still written at addr 0).

Source files
------------

// File: rtl/im_loader_if.sv
// Byte-stream / IM-write bundle for the instruction-memory loader.
// Handshake: a byte moves on a rising clk edge exactly when byte_valid and
// byte_ready are both 1; byte_data must be stable while byte_valid is high,
// and the loader raises byte_ready only in states that consume bytes.
interface im_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [31:0]       im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  // Host side: issues start/len and streams program bytes.
  modport master (
    output start, len, byte_valid, byte_data,
    input  byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err
  );

  // Loader side.
  modport slave (
    input  start, len, byte_valid, byte_data,
    output byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit
// words, writes them to the IM at word_index<<2 and holds the core until a
// load completes. Optional feature macro: CHECKSUM_EN (adds a trailing XOR
// checksum byte checked after the last word).
module im_loader #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  im_loader_if.slave  bus,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
`ifdef CHECKSUM_EN
    , S_CSUM = 3'd5
`endif
  } state_t;

  // Largest accepted program length: the whole IM.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              byte_acc;
  logic              start_ok;
  logic [ADDR_W:0]   idx_inc;
  state_t            after_last;

  assign byte_acc = bus.byte_valid && bus.byte_ready;
  assign start_ok = bus.start &&
                    (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign idx_inc  = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};

`ifdef CHECKSUM_EN
  assign after_last = S_CSUM;
`else
  assign after_last = S_DONE;
`endif

  // Next-state and datapath updates; every _d defaults to its register.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) begin
          len_d  = bus.len;
          idx_d  = '0;
          bcnt_d = '0;
`ifdef CHECKSUM_EN
          csum_d = '0;
`endif
          if (bus.len == '0)          state_d = after_last;
          else if (bus.len > MAX_LEN) state_d = S_ERR;
          else                        state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (byte_acc) begin
          bcnt_d = bcnt_q + 2'd1;
          word_d = {word_q[15:0], bus.byte_data};
`ifdef CHECKSUM_EN
          csum_d = csum_q ^ bus.byte_data;
`endif
          // Fourth byte completes the word: stage address/data for the strobe.
          if (bcnt_q == 2'd3) begin
            waddr_d = {{(30-ADDR_W){1'b0}}, idx_q, 2'b00};
            wdata_d = {word_q, bus.byte_data};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (idx_inc == len_q) begin
          state_d = after_last;
        end else begin
          idx_d   = idx_inc[ADDR_W-1:0];
          state_d = S_LOAD;
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        if (byte_acc) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Outputs decode straight from the registered state, so they are glitch-free
  // and already correct while reset is asserted.
`ifdef CHECKSUM_EN
  assign bus.byte_ready = (state_q == S_LOAD) || (state_q == S_CSUM);
`else
  assign bus.byte_ready = (state_q == S_LOAD);
`endif
  assign bus.im_we    = (state_q == S_WRITE);
  assign bus.im_waddr = waddr_q;
  assign bus.im_wdata = wdata_q;
  assign bus.cpu_hold = (state_q != S_DONE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = (state_q == S_ERR);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a queue of expected IM writes built from
// the program bytes, a negedge monitor comparing every write strobe, and
// directed plus randomized loads. Follows CHECKSUM_EN if defined.
module tb_im_loader;
  localparam int ADDR_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected {addr,data}.
  always @(negedge clk) begin
    if (mon_en && bus.im_we === 1'b1) begin
      last_waddr = bus.im_waddr;
      last_wdata = bus.im_wdata;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 bus.im_waddr, bus.im_wdata);
      end else begin
        check("im_write", {bus.im_waddr, bus.im_wdata}, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    bus.start = 1'b1;
    bus.len   = l[ADDR_W:0];
    tick();
    bus.start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps.
  // stray: pulse start once mid-transfer (must be ignored).
  task automatic send_bytes(input logic [7:0] b[$], input int mode, input bit stray);
    int i = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit stray_done = 1'b0;
    bit v;
    logic rdy;
    while (i < b.size() && cyc < 20 * b.size() + 50) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      tog = !tog;
      bus.byte_valid = v;
      bus.byte_data  = v ? b[i] : 8'($urandom_range(0, 255));
      if (stray && !stray_done && i == 1) begin
        bus.start  = 1'b1;
        bus.len    = (ADDR_W+1)'($urandom_range(0, 300));
        stray_done = 1'b1;
      end
      @(negedge clk);
      rdy = bus.byte_ready;
      @(posedge clk);
      if (v && rdy) i++;
      #1;
      bus.start = 1'b0;
      cyc++;
    end
    bus.byte_valid = 1'b0;
    if (i < b.size()) begin
      n_checks++;
      n_errors++;
      $display("FAIL byte_timeout: got %0d bytes accepted expected %0d", i, b.size());
    end
  endtask

  // Full load: model builds expected writes, then drive and check status.
  task automatic load(input int l, input logic [7:0] b[$], input int mode,
                      input bit stray, input int trailer);
    logic [7:0] tq[$];
    logic [7:0] x = 8'h00;
    logic [7:0] tr;
    bit ok;
    for (int k = 0; k < l; k++)
      exp_q.push_back({32'(k * 4), b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
    foreach (b[k]) x ^= b[k];
    do_start(l);
    check("load_hold", 64'(bus.cpu_hold), 64'(1));
    check("load_done_clr", 64'(bus.done), 64'(0));
    check("load_err_clr", 64'(bus.err), 64'(0));
    send_bytes(b, mode, stray);
    check("lat_we", 64'(bus.im_we), 64'(1));
`ifdef CHECKSUM_EN
    tr = (trailer < 0) ? x : trailer[7:0];
    ok = (tr == x);
    tq.push_back(tr);
    send_bytes(tq, 0, 1'b0);
    check("csum_done", 64'(bus.done), 64'(ok));
    check("csum_err", 64'(bus.err), 64'(!ok));
    check("csum_hold", 64'(bus.cpu_hold), 64'(!ok));
`else
    tr = 8'(trailer);
    ok = (tr == x) || 1'b1;
    tick();
    check("lat_done", 64'(bus.done), 64'(ok));
    check("lat_hold", 64'(bus.cpu_hold), 64'(0));
`endif
    check("all_writes", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic rand_bytes(input int l, output logic [7:0] b[$]);
    b.delete();
    for (int k = 0; k < 4 * l; k++) b.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [7:0] bq[$];
    int l;
    bus.start = 1'b0;
    bus.len = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;

    // 1: reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", 64'(bus.cpu_hold), 64'(1));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_err", 64'(bus.err), 64'(0));
    check("rst_ready", 64'(bus.byte_ready), 64'(0));
    check("rst_we", 64'(bus.im_we), 64'(0));
    check("rst_addr_data", {bus.im_waddr, bus.im_wdata}, 64'(0));
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    // byte_valid in IDLE is not consumed
    bus.byte_valid = 1'b1;
    tick();
    check("idle_ready", 64'(bus.byte_ready), 64'(0));
    bus.byte_valid = 1'b0;

    // 2: two words back-to-back
    bq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h12, 8'h34};
    load(2, bq, 0, 1'b0, -1);
    check("t2_last", {last_waddr, last_wdata}, {32'h4, 32'h3C011234});

    // 3: byte_valid toggling every cycle
    bq = '{8'h8C, 8'h22, 8'h00, 8'h04};
    load(1, bq, 1, 1'b0, -1);
    check("t3_last", {last_waddr, last_wdata}, {32'h0, 32'h8C220004});

    // 4: length boundaries
    do_start((1 << ADDR_W) + 1);
    check("len_over_err", 64'(bus.err), 64'(1));
    check("len_over_hold", 64'(bus.cpu_hold), 64'(1));
    do_start(0);
`ifdef CHECKSUM_EN
    bq = '{8'h00};
    send_bytes(bq, 0, 1'b0);
`endif
    check("len0_done", 64'(bus.done), 64'(1));
    check("len0_err", 64'(bus.err), 64'(0));
    do_start((1 << ADDR_W) + 1);
    check("len_over_err2", 64'(bus.err), 64'(1));
    rand_bytes(1, bq);
    load(1, bq, 2, 1'b0, -1);

    // 5: reset mid-word aborts, then fresh load from address 0
    do_start(1);
    bq = '{8'hAA, 8'hBB};
    send_bytes(bq, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(bus.byte_ready), 64'(0));
    check("abort_hold", 64'(bus.cpu_hold), 64'(1));
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_we", 64'(bus.im_we), 64'(0));
    rand_bytes(2, bq);
    load(2, bq, 0, 1'b1, -1);
    check("t5_last_addr", 64'(last_waddr), 64'h4);

    // Full-depth load: len == 2**ADDR_W is legal
    rand_bytes(1 << ADDR_W, bq);
    load(1 << ADDR_W, bq, 0, 1'b0, -1);
    check("full_last_addr", 64'(last_waddr), 64'h3FC);

`ifdef CHECKSUM_EN
    // 6: checksum trailer good and bad
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    load(1, bq, 0, 1'b0, 8'h04);
    check("t6_done", 64'(bus.done), 64'(1));
    load(1, bq, 0, 1'b0, 8'h05);
    check("t6_err", 64'(bus.err), 64'(1));
    check("t6_word", {last_waddr, last_wdata}, {32'h0, 32'h01020304});
`endif

    // Randomized loads with random gaps and stray start pulses
    repeat (25) begin
      l = $urandom_range(1, 6);
      rand_bytes(l, bq);
      load(l, bq, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : -1);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
